// File: rtl/instr_fetch_unit_if.sv
// +--------------------------------------------------------------------------+
// | instr_fetch_unit_if : program/control/issue bundle of instr_fetch_unit  |
// | Rev 1.0                                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

interface instr_fetch_unit_if #(
    parameter int AW = 6
);
    logic          start;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_data;
    logic          alu_zero;
    logic [31:0]   instrword;
    logic          newinstr;
    logic [31:0]   pc;
    logic          busy;
    logic          halted;

    modport master (
        output start, prog_we, prog_addr, prog_data, alu_zero,
        input  instrword, newinstr, pc, busy, halted
    );

    modport slave (
        input  start, prog_we, prog_addr, prog_data, alu_zero,
        output instrword, newinstr, pc, busy, halted
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// +--------------------------------------------------------------------------+
// | instr_fetch_unit : PC, loadable imem, BEQ resolution, timed issue       |
// | Optional J support when FETCH_JUMP_EN is defined.  Rev 1.0              |
// +--------------------------------------------------------------------------+
`default_nettype none

module instr_fetch_unit #(
    parameter int          IMEM_DEPTH  = 64,
    parameter int          EXEC_CYCLES = 4,
    parameter logic [31:0] PC_RESET    = 32'h0000_0000
) (
    input  wire logic clk,
    input  wire logic rst,
    instr_fetch_unit_if.slave bus
);

    localparam int              AW          = $clog2(IMEM_DEPTH);
    localparam int              CW          = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [31:0]     C_PC_RESET  = {PC_RESET[31:2], 2'b00};
    localparam logic [CW-1:0]   C_CNT_LOAD  = CW'(EXEC_CYCLES - 1);
    localparam logic [5:0]      C_OP_BEQ    = 6'd4;
    localparam logic [31:0]     C_SENTINEL  = 32'hFFFF_FFFF;
`ifdef FETCH_JUMP_EN
    localparam logic [5:0]      C_OP_J      = 6'd2;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_imem [IMEM_DEPTH];
    logic [31:0]     r_pc;
    logic [31:0]     w_pc_nxt;
    logic [31:0]     r_instr;
    logic [31:0]     w_instr_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [31:0]     w_fetch_word;
    logic [31:0]     w_pc4;
    logic [31:0]     w_pc_exec;
    logic            w_oob;
    logic [5:0]      w_opcode;
    logic [15:0]     w_imm;

    assign w_fetch_word = r_imem[r_pc[AW+1:2]];
    // The index above wraps, so the out-of-range test must gate it.
    assign w_oob        = ({2'b00, r_pc[31:2]} >= 32'(IMEM_DEPTH));
    assign w_pc4        = r_pc + 32'd4;
    assign w_opcode     = r_instr[31:26];
    assign w_imm        = r_instr[15:0];

    always_comb begin
        w_pc_exec = w_pc4;
        if (w_opcode == C_OP_BEQ && bus.alu_zero) begin
            w_pc_exec = w_pc4 + {{14{w_imm[15]}}, w_imm, 2'b00};
        end
`ifdef FETCH_JUMP_EN
        if (w_opcode == C_OP_J) begin
            w_pc_exec = {w_pc4[31:28], r_instr[25:0], 2'b00};
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_oob || w_fetch_word == C_SENTINEL) begin
                    w_instr_nxt = 32'h0;
                    w_state_nxt = S_HALT;
                end else begin
                    w_instr_nxt = w_fetch_word;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_cnt_nxt   = C_CNT_LOAD;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                // alu_zero only matters on the final execute cycle
                if (r_cnt == '0) begin
                    w_pc_nxt    = w_pc_exec;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= C_PC_RESET;
            r_instr <= 32'h0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Program contents survive rst on purpose.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && bus.prog_we) begin
            r_imem[bus.prog_addr] <= bus.prog_data;
        end
    end

    assign bus.instrword = r_instr;
    assign bus.newinstr  = (r_state == S_ISSUE);
    assign bus.pc        = r_pc;
    assign bus.busy      = (r_state == S_FETCH) || (r_state == S_ISSUE) || (r_state == S_EXEC);
    assign bus.halted    = (r_state == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// +--------------------------------------------------------------------------+
// | tb_instr_fetch_unit : directed bench for instr_fetch_unit               |
// | Rev 1.0                                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_instr_fetch_unit;

    localparam logic [31:0] C_ADD0   = 32'h012A_4020;
    localparam logic [31:0] C_ADD1   = 32'h014B_4820;
    localparam logic [31:0] C_ADD2   = 32'h016C_5020;
    localparam logic [31:0] C_BEQ_P2 = 32'h1000_0002;
    localparam logic [31:0] C_BEQ_M1 = 32'h1000_FFFF;
    localparam logic [31:0] C_J5     = 32'h0800_0005;
    localparam logic [31:0] C_STOP   = 32'hFFFF_FFFF;
`ifdef FETCH_JUMP_EN
    localparam logic [31:0] C_J_PC   = 32'h0000_0014;
`else
    localparam logic [31:0] C_J_PC   = 32'h0000_0004;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   n;

    instr_fetch_unit_if #(.AW(6)) if0 ();
    instr_fetch_unit_if #(.AW(2)) if1 ();

    instr_fetch_unit #(.IMEM_DEPTH(64), .EXEC_CYCLES(4), .PC_RESET(32'h0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    instr_fetch_unit #(.IMEM_DEPTH(4), .EXEC_CYCLES(4), .PC_RESET(32'h0)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic prog(input logic [5:0] a, input logic [31:0] d);
        if0.prog_we   = 1'b1;
        if0.prog_addr = a;
        if0.prog_data = d;
        tick();
        if0.prog_we   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic kick();
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
    endtask

    // Cycles until the next newinstr pulse; saturates at 50 on timeout.
    task automatic wait_issue(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!if0.newinstr && cyc < 50);
    endtask

    task automatic wait_halt(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!if0.halted && cyc < 50);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        if0.start = 1'b0; if0.prog_we = 1'b0; if0.prog_addr = '0; if0.prog_data = '0; if0.alu_zero = 1'b0;
        if1.start = 1'b0; if1.prog_we = 1'b0; if1.prog_addr = '0; if1.prog_data = '0; if1.alu_zero = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_pc",       if0.pc, 32'h0);
        chk("rst_instr",    if0.instrword, 32'h0);
        chk("rst_newinstr", {31'h0, if0.newinstr}, 32'h0);
        chk("rst_busy",     {31'h0, if0.busy}, 32'h0);
        chk("rst_halted",   {31'h0, if0.halted}, 32'h0);

        // Straight-line program ending on the sentinel
        prog(6'd0, C_ADD0);
        prog(6'd1, C_ADD1);
        prog(6'd2, C_ADD2);
        prog(6'd3, C_STOP);
        kick();
        chk("t1_fetch_busy", {31'h0, if0.busy}, 32'h1);
        chk("t1_fetch_nopulse", {31'h0, if0.newinstr}, 32'h0);
        wait_issue(n);
        chk("t1_lat0", n, 1);
        chk("t1_instr0", if0.instrword, C_ADD0);
        chk("t1_pc0", if0.pc, 32'h0);
        tick();
        chk("t1_pulse_one_cycle", {31'h0, if0.newinstr}, 32'h0);
        wait_issue(n);
        chk("t1_gap1", n, 5);
        chk("t1_instr1", if0.instrword, C_ADD1);
        chk("t1_pc1", if0.pc, 32'h4);
        wait_issue(n);
        chk("t1_gap2", n, 6);
        chk("t1_instr2", if0.instrword, C_ADD2);
        chk("t1_pc2", if0.pc, 32'h8);
        wait_halt(n);
        chk("t1_halt_lat", n, 6);
        chk("t1_halted", {31'h0, if0.halted}, 32'h1);
        chk("t1_busy", {31'h0, if0.busy}, 32'h0);
        chk("t1_pc_halt", if0.pc, 32'hC);
        chk("t1_instr_halt", if0.instrword, 32'h0);
        kick();
        chk("t1_start_in_halt", {31'h0, if0.halted}, 32'h1);

        // BEQ +2 taken
        do_reset();
        prog(6'd0, C_ADD0);
        prog(6'd1, C_BEQ_P2);
        prog(6'd2, C_STOP);
        prog(6'd4, C_STOP);
        if0.alu_zero = 1'b1;
        kick();
        wait_issue(n);
        wait_issue(n);
        chk("t2_beq_instr", if0.instrword, C_BEQ_P2);
        chk("t2_beq_pc", if0.pc, 32'h4);
        wait_halt(n);
        chk("t2_taken_pc", if0.pc, 32'h10);

        // BEQ +2 not taken: alu_zero high except in the deciding cycle
        do_reset();
        if0.alu_zero = 1'b0;
        kick();
        wait_issue(n);
        wait_issue(n);
        if0.alu_zero = 1'b1;
        repeat (4) tick();
        if0.alu_zero = 1'b0;
        wait_halt(n);
        chk("t2_nt_pc", if0.pc, 32'h8);
        chk("t2_nt_halted", {31'h0, if0.halted}, 32'h1);

        // BEQ -1 loops on itself until alu_zero drops
        do_reset();
        prog(6'd0, C_ADD0);
        prog(6'd1, C_ADD1);
        prog(6'd2, C_BEQ_M1);
        prog(6'd3, C_STOP);
        if0.alu_zero = 1'b1;
        kick();
        wait_issue(n);
        wait_issue(n);
        wait_issue(n);
        chk("t3_pc_first", if0.pc, 32'h8);
        wait_issue(n);
        chk("t3_reissue_gap", n, 6);
        chk("t3_reissue_pc", if0.pc, 32'h8);
        chk("t3_reissue_instr", if0.instrword, C_BEQ_M1);
        wait_issue(n);
        chk("t3_reissue2_pc", if0.pc, 32'h8);
        if0.alu_zero = 1'b0;
        wait_halt(n);
        chk("t3_exit_pc", if0.pc, 32'hC);

        // Small imem without sentinel runs off the end
        for (int i = 0; i < 4; i++) begin
            if1.prog_we   = 1'b1;
            if1.prog_addr = 2'(i);
            if1.prog_data = C_ADD0 + 32'(i);
            tick();
        end
        if1.prog_we = 1'b0;
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        n = 0;
        for (int i = 0; i < 200 && !if1.halted; i++) begin
            tick();
            if (if1.newinstr) n++;
        end
        chk("t4_issues", n, 4);
        chk("t4_halted", {31'h0, if1.halted}, 32'h1);
        chk("t4_pc", if1.pc, 32'h10);
        chk("t4_instr", if1.instrword, 32'h0);
        chk("t4_busy", {31'h0, if1.busy}, 32'h0);

        // Reset mid-EXEC; program write while busy must be dropped
        do_reset();
        prog(6'd0, C_ADD2);
        kick();
        wait_issue(n);
        tick();
        tick();
        if0.prog_we   = 1'b1;
        if0.prog_addr = 6'd0;
        if0.prog_data = 32'hDEAD_BEEF;
        tick();
        if0.prog_we   = 1'b0;
        chk("t5_in_exec", {31'h0, if0.busy}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", {31'h0, if0.busy}, 32'h0);
        chk("t5_pc", if0.pc, 32'h0);
        chk("t5_newinstr", {31'h0, if0.newinstr}, 32'h0);
        chk("t5_instr", if0.instrword, 32'h0);
        chk("t5_halted", {31'h0, if0.halted}, 32'h0);
        kick();
        wait_issue(n);
        chk("t5_imem_kept", if0.instrword, C_ADD2);

        // Jump handling depends on build configuration
        do_reset();
        prog(6'd0, C_J5);
        prog(6'd1, C_STOP);
        prog(6'd5, C_STOP);
        kick();
        wait_issue(n);
        chk("t6_j_instr", if0.instrword, C_J5);
        wait_halt(n);
        chk("t6_j_pc", if0.pc, C_J_PC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
